mem_stage: RTL and testbench
============================

# mem_stage

Memory-access pipeline stage between `exe_stage` and the write-back stage. It takes the EXE result bus and waits for the data-SRAM response of the load/store issued in EXE. It sign- or zero-extends load data per access size and alignment, then forwards the final result to WB. It also drives the MEM forward/stall bus consumed by decode.

## Interface
Parameters: none. Widths come from `mycpu.h`:
- `ES_TO_MS_BUS_WD` = 77
- `MS_TO_WS_BUS_WD` = 70
- `MS_FWD_BUS_WD` = 39

Ports:
- `clk`  in  1  single clock; one clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `ws_allowin`  in  1  WB can accept this cycle
- `ms_allowin`  out  1  MEM can accept this cycle
- `es_to_ms_valid`  in  1  EXE presents a valid instruction
- `es_to_ms_bus`  in  77  fields:
  - `load_type[2:0]` 76:74
  - `addr_lo[1:0]` 73:72
  - `mem_req` 71
  - `res_from_mem` 70
  - `gr_we` 69
  - `dest[4:0]` 68:64
  - `es_res[31:0]` 63:32
  - `pc[31:0]` 31:0
- `ms_to_ws_valid`  out  1  valid result to WB
- `ms_to_ws_bus`  out  70  fields:
  - `gr_we` 69
  - `dest` 68:64
  - `final_result` 63:32
  - `pc` 31:0
- `data_sram_data_ok`  in  1  response strobe for the oldest outstanding data request
- `data_sram_rdata`  in  32  read data, valid only while `data_ok`=1
- `ms_fwd_bus`  out  39  fields:
  - `ms_load_pending` 38
  - `ms_block_valid` 37
  - `dest` 36:32
  - `final_result` 31:0

## Operation
- Pipeline registers:
  - `ms_valid`, reset 0.
  - `es_to_ms_bus_r`, loaded when `es_to_ms_valid && ms_allowin`.
  - `ms_valid <= es_to_ms_valid` whenever `ms_allowin`.
- `load_type` encoding (`mycpu.h`): `LT_W`=0, `LT_B`=1, `LT_BU`=2, `LT_H`=3, `LT_HU`=4. Codes 5–7 are reserved and treated as `LT_W`.
- `mem_req`=1 marks an instruction whose request (load or store) was accepted in EXE. Exactly one `data_ok` is owed for it.
- Response buffer:
  - Registers `rbuf_valid` (reset 0) and `rbuf_data[31:0]`.
  - Capture when `data_ok && ms_valid && mem_req && !rbuf_valid && !(ms_to_ws_valid && ws_allowin)`.
  - Clear on any MEM→WB transfer, and on `reset`.
- Current read data: `cur_rdata = rbuf_valid ? rbuf_data : data_sram_rdata`.
- `data_ok` is ignored when `!ms_valid`, `!mem_req`, or `rbuf_valid`. No such case occurs in a correct system; it must not corrupt state.
- `ms_ready_go = !mem_req || rbuf_valid || data_sram_data_ok`.
- Handshake:
  - `ms_allowin = !ms_valid || (ms_ready_go && ws_allowin)`
  - `ms_to_ws_valid = ms_valid && ms_ready_go`
- Load alignment (byte lane `k = addr_lo`):
  - `LT_B`: sign-extend `cur_rdata[8k+7:8k]`.
  - `LT_BU`: zero-extend `cur_rdata[8k+7:8k]`.
  - `LT_H`: sign-extend `cur_rdata[16h+15:16h]`, where `h = addr_lo[1]`.
  - `LT_HU`: zero-extend the same halfword.
  - `LT_W`: `cur_rdata`.
  - `addr_lo[0]` is ignored for halfwords; misalignment is not checked here.
- `final_result = res_from_mem ? aligned_load : es_res`. Stores carry `es_res` with `gr_we`=0.
- Forward bus:
  - `ms_block_valid = ms_valid && gr_we`.
  - `ms_load_pending = ms_valid && res_from_mem && !ms_ready_go`. Decode must stall on a `dest` match while this is set.

## Timing
- Reset values: `ms_valid`=0, `rbuf_valid`=0. Therefore after reset `ms_to_ws_valid`=0, `ms_allowin`=1, and `ms_fwd_bus[38:37]`=0.
- Non-memory instruction: one cycle in MEM; back-to-back throughput of 1 per cycle when `ws_allowin`=1.
- Memory instruction: leaves MEM in the same cycle `data_ok` arrives, provided `ws_allowin`=1. Minimum residency is 1 cycle (`data_ok` in the first MEM cycle); maximum is unbounded.
- `data_ok` with `ws_allowin`=0: data is captured into `rbuf`. The instruction then holds with `ms_to_ws_valid`=1 and a stable `final_result` until `ws_allowin`.
- `data_ok` and a transfer in the same cycle: data bypasses `rbuf` (no capture), and `rbuf_valid` stays 0.
- Reset mid-wait: `ms_valid` and `rbuf_valid` clear next edge. A discarded outstanding `data_ok` is then dropped by the ignore rule.

## Structure
- `mycpu.h` holds:
  - the `ES_TO_MS_BUS_WD` / `MS_TO_WS_BUS_WD` / `MS_FWD_BUS_WD` defines
  - the `LT_*` codes
- Sub-module `load_align` (purely combinational): inputs `load_type`, `addr_lo`, `rdata`; output `aligned[31:0]`.
- `mem_stage` holds the pipeline register, response buffer and handshake logic.

## Test plan
- `LT_B`, `addr_lo`=3, `rdata`=0x80112233, `data_ok` in the 1st MEM cycle, `ws_allowin`=1 → `final_result`=0xFFFFFF80 with `ms_to_ws_valid` the same cycle. `LT_BU` with the same stimulus → 0x00000080.
- `LT_H`/`LT_HU` at `addr_lo`=2 with `rdata`=0x80011234 → 0xFFFF8001 / 0x00008001. At `addr_lo`=0 → 0x00001234 for both.
- Load with `data_ok` 3 cycles late → `ms_to_ws_valid`=0 and `ms_load_pending`=1 for 3 cycles; `ms_allowin`=0 throughout; EXE bus held.
- `data_ok` (`rdata`=0xDEADBEEF) while `ws_allowin`=0 for 2 cycles, then `rdata` bus driven to 0x0 → WB receives 0xDEADBEEF when `ws_allowin` rises.
- Four back-to-back ALU instructions (`mem_req`=0, `es_res` 1..4) → `ms_to_ws_valid` high for 4 consecutive cycles with results 1..4. A store (`mem_req`=1, `gr_we`=0) waits for `data_ok`, and `ms_block_valid`=0 while it does.
- Reset asserted while a load waits for `data_ok` → next cycle `ms_valid`=0 and `ms_allowin`=1. A stray `data_ok` after reset leaves `rbuf_valid`=0 and emits nothing.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared widths, load-type codes and the EXE->MEM bus layout for the MEM stage.
package mem_stage_pkg;

   localparam int ES_TO_MS_BUS_WD = 77;
   localparam int MS_TO_WS_BUS_WD = 70;
   localparam int MS_FWD_BUS_WD   = 39;

   localparam logic [2:0] LT_W  = 3'd0;
   localparam logic [2:0] LT_B  = 3'd1;
   localparam logic [2:0] LT_BU = 3'd2;
   localparam logic [2:0] LT_H  = 3'd3;
   localparam logic [2:0] LT_HU = 3'd4;

   typedef struct packed {
      logic [2:0]  load_type;
      logic [1:0]  addr_lo;
      logic        mem_req;
      logic        res_from_mem;
      logic        gr_we;
      logic [4:0]  dest;
      logic [31:0] es_res;
      logic [31:0] pc;
   } es_to_ms_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load data extraction: selects byte/halfword lane and extends it.
module load_align
   import mem_stage_pkg::*;
(
   input  logic [2:0]  load_type,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] aligned
);

   logic [7:0]  lane [4];
   logic [7:0]  sel_byte;
   logic [15:0] sel_half;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = rdata[8*gi +: 8];
      end
   endgenerate

   assign sel_byte = lane[addr_lo];
   // addr_lo[0] is deliberately ignored for halfword accesses
   assign sel_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

   always_comb begin
      aligned = rdata;
      case (load_type)
         LT_B:    aligned = {{24{sel_byte[7]}}, sel_byte};
         LT_BU:   aligned = {24'd0, sel_byte};
         LT_H:    aligned = {{16{sel_half[15]}}, sel_half};
         LT_HU:   aligned = {16'd0, sel_half};
         default: aligned = rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data-SRAM response, aligns load data and
// hands the result to WB; also publishes the forward/stall bus for decode.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   input  logic                       data_sram_data_ok,
   input  logic [31:0]                data_sram_rdata,
   output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

   es_to_ms_t   es_bus_q, es_bus_d;
   logic        ms_valid_q, ms_valid_d;
   logic        rbuf_valid_q, rbuf_valid_d;
   logic [31:0] rbuf_data_q, rbuf_data_d;

   logic        ms_ready_go;
   logic        ms_fire;
   logic        rbuf_capture;
   logic [31:0] cur_rdata;
   logic [31:0] aligned;
   logic [31:0] final_result;

   assign ms_ready_go    = !es_bus_q.mem_req || rbuf_valid_q || data_sram_data_ok;
   assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
   assign ms_fire        = ms_to_ws_valid && ws_allowin;

   // A response is buffered only when it cannot leave this cycle; stray
   // strobes (no valid memory instruction, or already buffered) are dropped.
   assign rbuf_capture = data_sram_data_ok && ms_valid_q && es_bus_q.mem_req
                         && !rbuf_valid_q && !ms_fire;

   assign cur_rdata = rbuf_valid_q ? rbuf_data_q : data_sram_rdata;

   load_align u_load_align (
      .load_type (es_bus_q.load_type),
      .addr_lo   (es_bus_q.addr_lo),
      .rdata     (cur_rdata),
      .aligned   (aligned)
   );

   assign final_result = es_bus_q.res_from_mem ? aligned : es_bus_q.es_res;

   always_comb begin
      ms_valid_d   = ms_valid_q;
      es_bus_d     = es_bus_q;
      rbuf_valid_d = rbuf_valid_q;
      rbuf_data_d  = rbuf_data_q;
      if (ms_allowin) begin
         ms_valid_d = es_to_ms_valid;
      end
      if (es_to_ms_valid && ms_allowin) begin
         es_bus_d = es_to_ms_t'(es_to_ms_bus);
      end
      if (ms_fire) begin
         rbuf_valid_d = 1'b0;
      end else if (rbuf_capture) begin
         rbuf_valid_d = 1'b1;
         rbuf_data_d  = data_sram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ms_valid_q   <= 1'b0;
         rbuf_valid_q <= 1'b0;
         es_bus_q     <= '0;
         rbuf_data_q  <= '0;
      end else begin
         ms_valid_q   <= ms_valid_d;
         rbuf_valid_q <= rbuf_valid_d;
         es_bus_q     <= es_bus_d;
         rbuf_data_q  <= rbuf_data_d;
      end
   end

   assign ms_to_ws_bus = {es_bus_q.gr_we, es_bus_q.dest, final_result, es_bus_q.pc};

   assign ms_fwd_bus = {ms_valid_q && es_bus_q.res_from_mem && !ms_ready_go,
                        ms_valid_q && es_bus_q.gr_we,
                        es_bus_q.dest,
                        final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load alignment, late/buffered responses,
// ALU throughput, stores and reset during an outstanding load.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ws_allowin;
   logic        ms_allowin;
   logic        es_to_ms_valid;
   logic [76:0] es_to_ms_bus;
   logic        ms_to_ws_valid;
   logic [69:0] ms_to_ws_bus;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic [38:0] ms_fwd_bus;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk               (clk),
      .reset             (reset),
      .ws_allowin        (ws_allowin),
      .ms_allowin        (ms_allowin),
      .es_to_ms_valid    (es_to_ms_valid),
      .es_to_ms_bus      (es_to_ms_bus),
      .ms_to_ws_valid    (ms_to_ws_valid),
      .ms_to_ws_bus      (ms_to_ws_bus),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .ms_fwd_bus        (ms_fwd_bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end else begin
         $display("ok   %s: %08h", tag, got);
      end
   endtask

   function automatic logic [76:0] mk_es(input logic [2:0] lt, input logic [1:0] alo,
                                         input logic mreq, input logic rfm, input logic gwe,
                                         input logic [4:0] dst, input logic [31:0] res,
                                         input logic [31:0] pc);
      return {lt, alo, mreq, rfm, gwe, dst, res, pc};
   endfunction

   // Advance to 1 time unit after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Load enters MEM, first checked without data_ok, then data_ok arrives in
   // the same (first) MEM cycle with ws_allowin=1.
   task automatic load_test(input string tag, input logic [2:0] lt, input logic [1:0] alo,
                            input logic [31:0] rdata, input logic [31:0] exp);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(lt, alo, 1'b1, 1'b1, 1'b1, 5'd7, 32'h0, 32'h1000);
      cyc();
      es_to_ms_valid = 1'b0;
      #1;
      chk({tag, " wait valid"}, 32'(ms_to_ws_valid), 32'd0);
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = rdata;
      #1;
      chk({tag, " valid"}, 32'(ms_to_ws_valid), 32'd1);
      chk({tag, " result"}, ms_to_ws_bus[63:32], exp);
      cyc();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h0;
      #1;
      chk({tag, " drained"}, 32'(ms_to_ws_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      ws_allowin = 1'b1;
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0;
      cyc();
      cyc();
      reset = 1'b0;
      #1;
      chk("reset valid", 32'(ms_to_ws_valid), 32'd0);
      chk("reset allowin", 32'(ms_allowin), 32'd1);
      chk("reset fwd flags", 32'(ms_fwd_bus[38:37]), 32'd0);

      // Alignment vectors
      load_test("LB a3", 3'd1, 2'd3, 32'h80112233, 32'hFFFFFF80);
      load_test("LBU a3", 3'd2, 2'd3, 32'h80112233, 32'h00000080);
      load_test("LB a1", 3'd1, 2'd1, 32'h80112233, 32'h00000022);
      load_test("LH a2", 3'd3, 2'd2, 32'h80011234, 32'hFFFF8001);
      load_test("LHU a2", 3'd4, 2'd2, 32'h80011234, 32'h00008001);
      load_test("LH a0", 3'd3, 2'd0, 32'h80011234, 32'h00001234);
      load_test("LHU a0", 3'd4, 2'd0, 32'h80011234, 32'h00001234);
      load_test("LH a3", 3'd3, 2'd3, 32'h80011234, 32'hFFFF8001);
      load_test("LW", 3'd0, 2'd0, 32'h80011234, 32'h80011234);
      load_test("LT rsvd7", 3'd7, 2'd1, 32'hCAFEF00D, 32'hCAFEF00D);

      // Late data_ok: EXE holds an ALU op behind the waiting load
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 5'd9, 32'h0, 32'h2000);
      cyc();
      es_to_ms_bus   = mk_es(3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h77, 32'h2004);
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("late%0d valid", i), 32'(ms_to_ws_valid), 32'd0);
         chk($sformatf("late%0d pending", i), 32'(ms_fwd_bus[38]), 32'd1);
         chk($sformatf("late%0d allowin", i), 32'(ms_allowin), 32'd0);
         cyc();
      end
      data_sram_data_ok = 1'b1;
      data_sram_rdata   = 32'h12345678;
      #1;
      chk("late result", ms_to_ws_bus[63:32], 32'h12345678);
      chk("late allowin", 32'(ms_allowin), 32'd1);
      chk("late pending off", 32'(ms_fwd_bus[38]), 32'd0);
      cyc();
      es_to_ms_valid = 1'b0;
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0;
      #1;
      chk("held alu valid", 32'(ms_to_ws_valid), 32'd1);
      chk("held alu result", ms_to_ws_bus[63:32], 32'h77);
      chk("held alu dest", 32'(ms_to_ws_bus[68:64]), 32'd3);
      cyc();

      // data_ok while WB stalls: response must be buffered
      es_to_ms_valid = 1'b1;
      es_to_ms_bus   = mk_es(3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 5'd4, 32'h0, 32'h3000);
      cyc();
      es_to_ms_valid = 1'b0;
      ws_allowin = 1'b0;
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'hDEADBEEF;
      #1;
      chk("rbuf stall valid", 32'(ms_to_ws_valid), 32'd1);
      chk("rbuf stall allowin", 32'(ms_allowin), 32'd0);
      cyc();
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0;
      #1;
      chk("rbuf held valid", 32'(ms_to_ws_valid), 32'd1);
      chk("rbuf held result", ms_to_ws_bus[63:32], 32'hDEADBEEF);
      cyc();
      ws_allowin = 1'b1;
      #1;
      chk("rbuf release result", ms_to_ws_bus[63:32], 32'hDEADBEEF);
      chk("rbuf release allowin", 32'(ms_allowin), 32'd1);
      cyc();
      #1;
      chk("rbuf drained", 32'(ms_to_ws_valid), 32'd0);

      // Four back-to-back ALU instructions
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'd1, 32'h4000);
      for (int k = 1; k <= 4; k++) begin
         cyc();
         if (k < 4)
            es_to_ms_bus = mk_es(3'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd1, 32'(k + 1), 32'h4000);
         else
            es_to_ms_valid = 1'b0;
         #1;
         chk($sformatf("alu%0d valid", k), 32'(ms_to_ws_valid), 32'd1);
         chk($sformatf("alu%0d result", k), ms_to_ws_bus[63:32], 32'(k));
      end
      cyc();

      // Store waits for data_ok and never blocks decode
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd6, 32'h00000ABC, 32'h5000);
      cyc();
      es_to_ms_valid = 1'b0;
      #1;
      chk("store wait valid", 32'(ms_to_ws_valid), 32'd0);
      chk("store fwd flags", 32'(ms_fwd_bus[38:37]), 32'd0);
      cyc();
      data_sram_data_ok = 1'b1;
      #1;
      chk("store valid", 32'(ms_to_ws_valid), 32'd1);
      chk("store result", ms_to_ws_bus[63:32], 32'h00000ABC);
      chk("store gr_we", 32'(ms_to_ws_bus[69]), 32'd0);
      cyc();
      data_sram_data_ok = 1'b0;

      // Reset while a load waits, then a stray data_ok
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 5'd8, 32'h0, 32'h6000);
      cyc();
      es_to_ms_valid = 1'b0;
      #1;
      chk("pre-reset pending", 32'(ms_fwd_bus[38]), 32'd1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #1;
      chk("mid reset valid", 32'(ms_to_ws_valid), 32'd0);
      chk("mid reset allowin", 32'(ms_allowin), 32'd1);
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'h55555555;
      #1;
      chk("stray valid", 32'(ms_to_ws_valid), 32'd0);
      cyc();
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0;
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_es(3'd0, 2'd0, 1'b1, 1'b1, 1'b1, 5'd2, 32'h0, 32'h7000);
      cyc();
      es_to_ms_valid = 1'b0;
      #1;
      chk("post stray wait", 32'(ms_to_ws_valid), 32'd0);
      data_sram_data_ok = 1'b1;
      data_sram_rdata = 32'h0BADF00D;
      #1;
      chk("post stray result", ms_to_ws_bus[63:32], 32'h0BADF00D);
      cyc();
      data_sram_data_ok = 1'b0;
      #1;
      chk("final idle", 32'(ms_to_ws_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
